// File: rtl/cmp_sort_engine.sv
// Block sorter: load DEPTH words, bubble-sort in place with one shared comparator, then stream out.
// Latency is DEPTH-1 to DEPTH(DEPTH-1)/2 sort cycles per block; output holds under out_ready=0; no input accepted outside LOAD.
module cmp_sort_engine #(
   parameter int WIDTH   = 4,
   parameter int DEPTH   = 8,
   parameter bit DESCEND = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   pass_cnt
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

   typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] buf_q [DEPTH];
   logic [WIDTH-1:0] buf_d [DEPTH];
   logic [CW-1:0]    wr_idx_q, wr_idx_d;
   logic [CW-1:0]    rd_idx_q, rd_idx_d;
   logic [CW-1:0]    i_q, i_d;
   logic [CW-1:0]    lim_q, lim_d;
   logic             swapped_q, swapped_d;
   logic [CW-1:0]    pass_cnt_q, pass_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_last_q, out_last_d;

   logic [AW-1:0]    ia, ib;
   logic [WIDTH-1:0] cmp_a, cmp_b;
   logic             cmp_eq, cmp_lt, cmp_gt, swap;
   logic             end_of_pass, sort_done;
   logic             accept, load_done, out_fire, drain_done;
   logic [CW-1:0]    rd_next;

   // The single shared comparator, steered to the current adjacent pair.
   assign ia     = i_q[AW-1:0];
   assign ib     = ia + AW'(1);
   assign cmp_a  = buf_q[ia];
   assign cmp_b  = buf_q[ib];
   assign cmp_eq = (cmp_a == cmp_b);
   assign cmp_lt = (cmp_a < cmp_b);
   assign cmp_gt = !(cmp_lt || cmp_eq);
   assign swap   = DESCEND ? cmp_lt : cmp_gt;

   assign end_of_pass = (i_q == lim_q - CW'(1));
   assign sort_done   = end_of_pass && (!(swapped_q || swap) || (lim_q == CW'(1)));
   assign accept      = in_valid && (state_q == S_LOAD);
   assign load_done   = accept && (wr_idx_q == LAST_IDX);
   assign out_fire    = out_valid_q && out_ready && (state_q == S_DRAIN);
   assign drain_done  = out_fire && (rd_idx_q == LAST_IDX);
   assign rd_next     = rd_idx_q + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_LOAD;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:  if (load_done)  state_d = S_SORT;
         S_SORT:  if (sort_done)  state_d = S_DRAIN;
         S_DRAIN: if (drain_done) state_d = S_LOAD;
         default:                 state_d = S_LOAD;
      endcase
   end

   always_comb begin
      in_ready = (state_q == S_LOAD);
      busy     = (state_q == S_SORT);
   end

   always_comb begin
      buf_d       = buf_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      i_d         = i_q;
      lim_d       = lim_q;
      swapped_d   = swapped_q;
      pass_cnt_d  = pass_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      case (state_q)
         S_LOAD: begin
            if (accept) begin
               buf_d[wr_idx_q[AW-1:0]] = in_data;
               wr_idx_d = wr_idx_q + CW'(1);
               // pass_cnt of the previous block stays visible until new data arrives
               if (wr_idx_q == '0) pass_cnt_d = '0;
            end
            if (load_done) begin
               wr_idx_d  = '0;
               i_d       = '0;
               lim_d     = LAST_IDX;
               swapped_d = 1'b0;
            end
         end
         S_SORT: begin
            if (swap) begin
               buf_d[ia] = cmp_b;
               buf_d[ib] = cmp_a;
               swapped_d = 1'b1;
            end
            if (end_of_pass) begin
               pass_cnt_d = pass_cnt_q + CW'(1);
               if (sort_done) begin
                  i_d         = '0;
                  lim_d       = '0;
                  swapped_d   = 1'b0;
                  rd_idx_d    = '0;
                  out_valid_d = 1'b1;
                  out_data_d  = buf_d[0];
                  out_last_d  = 1'b0;
               end else begin
                  lim_d     = lim_q - CW'(1);
                  i_d       = '0;
                  swapped_d = 1'b0;
               end
            end else begin
               i_d = i_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (drain_done) begin
               rd_idx_d    = '0;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end else if (out_fire) begin
               rd_idx_d   = rd_next;
               out_data_d = buf_q[rd_next[AW-1:0]];
               out_last_d = (rd_next == LAST_IDX);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         i_q         <= '0;
         lim_q       <= '0;
         swapped_q   <= 1'b0;
         pass_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         i_q         <= i_d;
         lim_q       <= lim_d;
         swapped_q   <= swapped_d;
         pass_cnt_q  <= pass_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_cmp_sort_engine.sv
// Directed bench: ascending 4-bit instance and descending 8-bit instance share stimulus, selected by sel.
module tb_cmp_sort_engine;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       sel = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = 8'h0;

   logic       a_in_ready, a_out_valid, a_out_last, a_busy;
   logic [3:0] a_out_data;
   logic [3:0] a_pass_cnt;
   logic       b_in_ready, b_out_valid, b_out_last, b_busy;
   logic [7:0] b_out_data;
   logic [3:0] b_pass_cnt;

   logic       m_in_ready, m_out_valid, m_out_last, m_busy;
   logic [7:0] m_out_data;
   logic [3:0] m_pass_cnt;

   cmp_sort_engine #(.WIDTH(4), .DEPTH(8), .DESCEND(1'b0)) u_asc (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid && !sel), .in_ready(a_in_ready), .in_data(in_data[3:0]),
      .out_valid(a_out_valid), .out_ready(out_ready && !sel), .out_data(a_out_data),
      .out_last(a_out_last), .busy(a_busy), .pass_cnt(a_pass_cnt)
   );

   cmp_sort_engine #(.WIDTH(8), .DEPTH(8), .DESCEND(1'b1)) u_desc (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid && sel), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready && sel), .out_data(b_out_data),
      .out_last(b_out_last), .busy(b_busy), .pass_cnt(b_pass_cnt)
   );

   always_comb begin
      m_in_ready  = sel ? b_in_ready  : a_in_ready;
      m_out_valid = sel ? b_out_valid : a_out_valid;
      m_out_last  = sel ? b_out_last  : a_out_last;
      m_busy      = sel ? b_busy      : a_busy;
      m_out_data  = sel ? b_out_data  : {4'h0, a_out_data};
      m_pass_cnt  = sel ? b_pass_cnt  : a_pass_cnt;
   end

   int checks = 0;
   int errors = 0;
   int vec  [8];
   int expv [8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_block();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("in_ready_load", m_in_ready, 1);
         in_valid = 1'b1;
         in_data  = vec[k][7:0];
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("in_ready_sort", m_in_ready, 0);
   endtask

   task automatic sort_wait(input int exp_cyc, input int exp_pass);
      int cyc = 0;
      while (m_busy && cyc < 500) begin
         check("no_valid_in_sort", m_out_valid, 0);
         cyc++;
         @(negedge clk);
      end
      if (cyc >= 500) check("sort_timeout", 0, 1);
      if (exp_cyc >= 0)  check("sort_cycles", cyc, exp_cyc);
      if (exp_pass >= 0) check("pass_cnt", m_pass_cnt, exp_pass);
      check("valid_after_busy", m_out_valid, 1);
   endtask

   task automatic drain(input bit stall, input bit poke);
      int n = 0;
      int cyc = 0;
      bit prev_stall = 1'b0;
      logic [7:0] pd = 8'h0;
      logic pl = 1'b0;
      logic [3:0] pat = 4'b1001;
      while (n < 8 && cyc < 200) begin
         if (prev_stall) begin
            check("hold_data", m_out_data, pd);
            check("hold_last", m_out_last, pl);
         end
         out_ready = stall ? pat[cyc % 4] : 1'b1;
         if (poke) begin
            in_valid = !(m_out_valid && m_out_last && out_ready);
            in_data  = 8'hA5;
         end
         if (m_out_valid && out_ready) begin
            check("out_data", m_out_data, expv[n]);
            check("out_last", m_out_last, (n == 7));
            n++;
         end
         prev_stall = m_out_valid && !out_ready;
         pd = m_out_data;
         pl = m_out_last;
         cyc++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("handshakes", n, 8);
      check("valid_after_drain", m_out_valid, 0);
      check("in_ready_after_drain", m_in_ready, 1);
      @(negedge clk);
      check("no_extra_output", m_out_valid, 0);
   endtask

   initial begin
      @(negedge clk);
      check("rst_in_ready_a", a_in_ready, 1);
      check("rst_out_valid_a", a_out_valid, 0);
      check("rst_out_last_a", a_out_last, 0);
      check("rst_busy_a", a_busy, 0);
      check("rst_pass_a", a_pass_cnt, 0);
      check("rst_out_data_a", a_out_data, 0);
      check("rst_in_ready_b", b_in_ready, 1);
      check("rst_out_valid_b", b_out_valid, 0);
      rst_n = 1'b1;

      vec  = '{3, 1, 4, 1, 5, 9, 2, 6};
      expv = '{1, 1, 2, 3, 4, 5, 6, 9};
      load_block();
      sort_wait(25, 5);
      drain(1'b0, 1'b0);

      vec  = '{0, 1, 2, 3, 4, 5, 6, 7};
      expv = '{0, 1, 2, 3, 4, 5, 6, 7};
      load_block();
      sort_wait(7, 1);
      drain(1'b1, 1'b1);

      vec  = '{15, 14, 13, 12, 11, 10, 9, 8};
      expv = '{8, 9, 10, 11, 12, 13, 14, 15};
      load_block();
      sort_wait(28, 7);
      drain(1'b0, 1'b0);
      check("pass_held", m_pass_cnt, 7);

      sel  = 1'b1;
      vec  = '{2, 7, 7, 0, 15, 3, 3, 1};
      expv = '{15, 7, 7, 3, 3, 2, 1, 0};
      load_block();
      sort_wait(-1, -1);
      drain(1'b0, 1'b0);
      sel  = 1'b0;

      // Abort a block mid-sort and make sure none of it leaks out.
      vec = '{15, 14, 13, 12, 11, 10, 9, 8};
      load_block();
      repeat (5) @(negedge clk);
      check("busy_before_abort", m_busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", m_in_ready, 1);
      check("abort_busy", m_busy, 0);
      check("abort_pass", m_pass_cnt, 0);
      check("abort_out_valid", m_out_valid, 0);
      check("abort_out_data", m_out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("quiet_after_abort", m_out_valid, 0);
      end
      vec  = '{5, 5, 5, 5, 5, 5, 5, 5};
      expv = '{5, 5, 5, 5, 5, 5, 5, 5};
      load_block();
      sort_wait(7, 1);
      drain(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
